// File: rtl/seq_det_prog.sv
// rtl/seq_det_prog.sv - runtime-programmable serial bit-sequence detector with saturating match counter
module seq_det_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 'b1011,
    parameter int                 RST_LEN     = 4,
    parameter bit                 RST_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               count_clr,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_nx;
    logic               bits_eq;
    logic               accept;
    logic               match;

    // Only the low len bits take part in the compare; higher pattern bits are don't-care.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    always_comb begin
        cand    = {hist[MAX_LEN-2:0], in_bit};
        fill_nx = (fill >= LEN_MAX) ? LEN_MAX : fill + 1'b1;
        bits_eq = ((cand ^ pattern_q) & len_mask) == '0;
        accept  = in_valid && !cfg_load;
        match   = accept && (fill_nx >= len_q) && bits_eq && !cfg_err;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= RST_PATTERN;
            len_q     <= LEN_W'(RST_LEN);
            overlap_q <= RST_OVERLAP;
            cfg_err   <= 1'b0;
        end else if (cfg_load) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
            cfg_err   <= (cfg_len == '0) || (cfg_len > LEN_MAX);
        end
    end

    // Non-overlap mode restarts fill so the next match needs len fresh bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (cfg_load) begin
            hist <= '0;
            fill <= '0;
        end else if (in_valid) begin
            hist <= cand;
            fill <= (match && !overlap_q) ? '0 : fill_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            detected <= 1'b0;
        end else begin
            detected <= match;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_count <= '0;
        end else if (count_clr) begin
            match_count <= '0;
        end else if (match && (match_count != '1)) begin
            match_count <= match_count + 1'b1;
        end
    end

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
- Runtime-programmable serial bit-sequence detector. Successor to the fixed 1011 detector.
- Pattern length (1..MAX_LEN), pattern bits and overlap/non-overlap mode are loadable at run time. A valid-qualified input and a saturating match counter are added.
- Sits on serial data paths (framing/sync-word hunt). Reset configuration reproduces the fixed 1011, overlapping detector.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- CNT_W, 16, match counter width.
- RST_PATTERN, 'b1011, pattern loaded at reset (right-aligned).
- RST_LEN, 4, length loaded at reset.
- RST_OVERLAP, 1, overlap mode loaded at reset.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_load  in  1  latch cfg_* fields this cycle.
- cfg_pattern  in  MAX_LEN  pattern, right-aligned; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping matches allowed, 0 = restart after each match.
- in_valid  in  1  in_bit is sampled when high.
- in_bit  in  1  serial data.
- count_clr  in  1  synchronous clear of match_count.
- detected  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  number of matches, saturating.
- cfg_err  out  1  active configuration length is invalid.

Behaviour:

Reset (asynchronous, active-high):
- pattern=RST_PATTERN, len=RST_LEN, overlap=RST_OVERLAP.
- hist=0, fill=0, detected=0, match_count=0, cfg_err=0.

Registers:
- hist[MAX_LEN-1:0]: shift history.
- fill: bits accepted since last restart, saturating at MAX_LEN.
- Active pattern, len and overlap.

Accept (in_valid=1, cfg_load=0):
- cand = {hist[MAX_LEN-2:0], in_bit}; hist <= cand.
- fill_nx = min(fill+1, MAX_LEN).
- match = (fill_nx >= len) and (cand[len-1:0] == pattern[len-1:0]) and not cfg_err.

Timing:
- detected <= match. It is high for exactly the one cycle following the edge that sampled the final pattern bit; latency is 1 cycle.
- With in_valid=0, hist and fill hold and detected <= 0.
- Back-to-back matches produce back-to-back pulses.

Mode on match:
- Overlap: fill <= fill_nx, so history bits are reused.
- Non-overlap: fill <= 0, so the next match needs len fresh bits.

Config load (cfg_load=1):
- Latches pattern, len and overlap; clears hist and fill; detected <= 0.
- cfg_err <= (cfg_len==0 or cfg_len>MAX_LEN).
- In-flight partial matches are discarded.
- cfg_load wins over in_valid in the same cycle: that in_bit is dropped and not shifted in.

Invalid length:
- While cfg_err=1, match is forced to 0. Bits still shift.
- cfg_err is cleared only by a valid load or by reset.

len=1:
- Every accepted bit equal to pattern[0] matches, in both modes.

match_count:
- Increments on each match and saturates at 2^CNT_W-1; no wrap.
- count_clr has priority over a same-cycle match: the result is 0 and that match is not counted. detected still pulses.
- Not affected by cfg_load.

Reset mid-sequence:
- Immediately forces all outputs to reset values.
- A partial match never completes across reset.

Pattern bits:
- pattern bits above len-1 are ignored.

Test Plan:
1. After reset, with in_valid=1 every cycle, feed 1,0,1,1,0,1,1 -> detected pulses after bit 4 and bit 7; match_count=2.
2. Load pattern 'b1011, len 4, overlap 0; feed 1,0,1,1,0,1,1,1,0,1,1 -> pulse after bit 4 only, then after bit 11 (bits 8-11). After bit 7 there is no pulse: bits 5-7 are only 3 fresh bits. match_count=2.
3. Feed 1,0 with in_valid=1, hold in_valid=0 for 5 cycles, then feed 1,1 -> single pulse one cycle after the final 1; no pulses during the idle cycles.
4. Load len 6, pattern 'b110010; feed 1,1,0 then assert cfg_load with in_valid=1 in the same cycle; reload the same pattern; feed 0,1,0 -> no detect, because the history was cleared. Then feed 1,1,0,0,1,0 -> one pulse after the last bit.
5. Load len 0 -> cfg_err=1; feed 1,0,1,1 repeatedly -> detected stays 0. Then load len 9 with MAX_LEN=8 -> cfg_err stays 1. Then load len 4, pattern 1011 -> cfg_err=0 and detection resumes.
6. With CNT_W=2, produce 5 matches -> match_count stops at 3. Then count_clr in the same cycle as a match -> count=0 and detected=1. Then assert async reset mid-pattern after 1,0,1 and feed 1 -> no pulse, all outputs 0.
